regfile_onehot: RTL and testbench
=================================

REGFILE_ONEHOT -- requirements
Module: regfile_onehot

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning register data width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, an asynchronous, active-low reset.
REQ-004 The block SHALL have port wr_sel, input, 32 bits, a one-hot write-select vector from the upstream 5-to-32 decoder.
REQ-005 The block SHALL have port wr_en, input, 1 bit, which qualifies wr_sel and wr_data for one cycle.
REQ-006 The block SHALL have port wr_data, input, DW bits, the write data.
REQ-007 The block SHALL have ports rd_addr_a and rd_addr_b, input, 5 bits each, the read addresses.
REQ-008 The block SHALL have port rd_req, input, 1 bit, which qualifies both read addresses.
REQ-009 The block SHALL have ports rd_data_a and rd_data_b, output, DW bits each, the registered read data.
REQ-010 The block SHALL have port rd_valid, output, 1 bit, high for one cycle when rd_data_a/b are updated.
REQ-011 The block SHALL have port sel_err, output, 1 bit, a sticky flag for an illegal wr_sel.
REQ-012 The block SHALL have port err_cnt, output, 8 bits, a saturating count of illegal write attempts.

Function
REQ-013 The block SHALL hold 32 registers of DW bits, index i selected by wr_sel[i].
REQ-014 The block SHALL treat a write as legal when wr_en=1 and wr_sel has exactly one bit set.
REQ-015 On a legal write, the block SHALL load register i with wr_data at the clock edge; the new value is readable from the next cycle.
REQ-016 On wr_en=1 with wr_sel zero or multi-hot (e.g. 32'd123), the block SHALL write no register, set sel_err=1, and increment err_cnt.
REQ-017 err_cnt SHALL saturate at 8'hFF and not wrap.
REQ-018 sel_err SHALL remain 1 until reset.
REQ-019 When wr_en=0, the block SHALL ignore wr_sel entirely; it SHALL perform no write and SHALL NOT check wr_sel.
REQ-020 When rd_req=1, the block SHALL register both read results at the edge, giving 1-cycle latency, and assert rd_valid in the following cycle.
REQ-021 When rd_req=0, the block SHALL hold rd_data_a/b and drive rd_valid=0.
REQ-022 If rd_addr_a equals rd_addr_b, both outputs SHALL return the same value.
REQ-023 Back-to-back rd_req cycles SHALL each produce one rd_valid pulse, giving full throughput.
REQ-024 A read and a legal write to the same register in the same cycle SHALL return data as defined in REQ-029/REQ-030.

Reset
REQ-025 When rst=0, the block SHALL asynchronously clear all 32 registers, rd_data_a, rd_data_b, rd_valid, sel_err, and err_cnt to 0.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight read, so no rd_valid occurs after reset release for a read requested before reset.
REQ-027 A write coincident with the reset-release edge SHALL be honoured only if rst is sampled high at that edge.

Configuration
REQ-028 The block SHALL provide the compile-time macro REGFILE_BYPASS_EN to control same-cycle write-to-read forwarding.
REQ-029 With REGFILE_BYPASS_EN defined, a same-cycle legal write to a register being read SHALL forward wr_data to the matching rd_data output.
REQ-030 Without REGFILE_BYPASS_EN, a same-cycle legal write to a register being read SHALL return the old register contents; no forwarding logic SHALL be present.
REQ-031 Illegal writes SHALL never be forwarded in either configuration.

Verification
REQ-032 The bench SHALL cover: reset, then rd_req with addr_a=0 and addr_b=31 -> rd_valid=1 next cycle, both data outputs 0.
REQ-033 The bench SHALL cover: write wr_sel=32'h0000_0020 with data 32'hDEAD_BEEF, then read addr_a=5 -> rd_data_a=32'hDEAD_BEEF.
REQ-034 The bench SHALL cover: wr_en=1 with wr_sel=32'd123 and data 32'h1 -> no register changes, sel_err=1, err_cnt=1; 300 further illegal writes -> err_cnt=8'hFF.
REQ-035 The bench SHALL cover: same-cycle write 32'hA5A5_A5A5 to register 7 and read addr_a=7 while register 7 holds 32'h1 -> rd_data_a=32'hA5A5_A5A5 with bypass, 32'h1 without.
REQ-036 The bench SHALL cover: rd_req asserted, then rst pulled low before the next edge -> rd_valid stays 0, all outputs 0, no stale pulse after release.
REQ-037 The bench SHALL cover: writes to all 32 registers with data=index, then 16 back-to-back reads of pairs (i, 31-i) -> 16 consecutive rd_valid pulses with correct data.

Source files
------------

// File: rtl/regfile_onehot_if.sv
// Bus bundle for regfile_onehot: one-hot write port, dual read port, error status.
// master = driver of writes/reads (upstream logic), slave = the register file.
interface regfile_onehot_if #(
  parameter int DW = 32
) ();
  logic [31:0]   wr_sel;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [4:0]    rd_addr_a;
  logic [4:0]    rd_addr_b;
  logic          rd_req;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic          rd_valid;
  logic          sel_err;
  logic [7:0]    err_cnt;

  modport master (
    output wr_sel, wr_en, wr_data, rd_addr_a, rd_addr_b, rd_req,
    input  rd_data_a, rd_data_b, rd_valid, sel_err, err_cnt
  );

  modport slave (
    input  wr_sel, wr_en, wr_data, rd_addr_a, rd_addr_b, rd_req,
    output rd_data_a, rd_data_b, rd_valid, sel_err, err_cnt
  );
endinterface

// File: rtl/regfile_onehot.sv
// 32 x DW register file written through a one-hot select vector, with two
// registered read ports (1-cycle latency) and illegal-select detection.
// Optional macro REGFILE_BYPASS_EN: forward same-cycle legal write data to a
// read of the same register; when undefined the read returns the old contents.
// rst is asynchronous, active low.
module regfile_onehot #(
  parameter int DW = 32
) (
  input logic             clk,
  input logic             rst,
  regfile_onehot_if.slave bus
);

  logic [DW-1:0] regs [32];
  logic          sel_onehot;
  logic          wr_legal;
  logic          wr_illegal;
  logic [DW-1:0] rd_next_a;
  logic [DW-1:0] rd_next_b;

  // exactly one bit set: non-zero and clearing the lowest set bit leaves zero
  assign sel_onehot = (bus.wr_sel != 32'd0) &&
                      ((bus.wr_sel & (bus.wr_sel - 32'd1)) == 32'd0);
  assign wr_legal   = bus.wr_en && sel_onehot;
  assign wr_illegal = bus.wr_en && !sel_onehot;

  // read mux, with optional forwarding of a legal same-cycle write
  always_comb begin
    rd_next_a = regs[bus.rd_addr_a];
    rd_next_b = regs[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_legal && bus.wr_sel[bus.rd_addr_a]) rd_next_a = bus.wr_data;
    if (wr_legal && bus.wr_sel[bus.rd_addr_b]) rd_next_b = bus.wr_data;
`endif
  end

  // register array: load the selected entry on a legal write only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_legal) begin
      for (int i = 0; i < 32; i++) begin
        if (bus.wr_sel[i]) regs[i] <= bus.wr_data;
      end
    end
  end

  // registered read outputs; data holds when no request, valid pulses per request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rd_data_a <= '0;
      bus.rd_data_b <= '0;
      bus.rd_valid  <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_req;
      if (bus.rd_req) begin
        bus.rd_data_a <= rd_next_a;
        bus.rd_data_b <= rd_next_b;
      end
    end
  end

  // sticky error flag and saturating illegal-write counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.sel_err <= 1'b0;
      bus.err_cnt <= 8'd0;
    end else if (wr_illegal) begin
      bus.sel_err <= 1'b1;
      if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_regfile_onehot.sv
// Self-checking bench for regfile_onehot: directed scenarios plus randomized
// traffic compared against a behavioural model of the register file.
module tb_regfile_onehot;

  localparam int DW = 32;

  logic clk;
  logic rst;
  regfile_onehot_if #(.DW(DW)) bus ();

  regfile_onehot #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // reference model state
  logic [DW-1:0] mem [32];
  logic [DW-1:0] exp_a;
  logic [DW-1:0] exp_b;
  logic          exp_valid;
  logic          exp_err;
  int            exp_cnt;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    exp_a = '0; exp_b = '0; exp_valid = 1'b0; exp_err = 1'b0; exp_cnt = 0;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
  endtask

  // advance one clock edge, updating the model from the inputs seen at that edge
  task automatic tick();
    bit legal;
    legal = bus.wr_en && ($countones(bus.wr_sel) == 1);
    if (bus.rd_req) begin
      exp_a = mem[bus.rd_addr_a];
      exp_b = mem[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      if (legal && bus.wr_sel[bus.rd_addr_a]) exp_a = bus.wr_data;
      if (legal && bus.wr_sel[bus.rd_addr_b]) exp_b = bus.wr_data;
`endif
    end
    exp_valid = bus.rd_req;
    if (legal) begin
      for (int i = 0; i < 32; i++) if (bus.wr_sel[i]) mem[i] = bus.wr_data;
    end
    if (bus.wr_en && !legal) begin
      exp_err = 1'b1;
      if (exp_cnt < 255) exp_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.rd_valid); else passed++;
    total++; if (bus.rd_data_a !== '0) $display("FAIL reset_rd_a got %h exp 0", bus.rd_data_a); else passed++;
    total++; if (bus.rd_data_b !== '0) $display("FAIL reset_rd_b got %h exp 0", bus.rd_data_b); else passed++;
    total++; if (bus.sel_err !== 1'b0) $display("FAIL reset_sel_err got %b exp 0", bus.sel_err); else passed++;
    total++; if (bus.err_cnt !== 8'd0) $display("FAIL reset_err_cnt got %0d exp 0", bus.err_cnt); else passed++;
    bus.rd_req = 1'b1; bus.rd_addr_a = 5'd0; bus.rd_addr_b = 5'd31;
    tick();
    bus.rd_req = 1'b0;
    total++; if (bus.rd_valid !== 1'b1) $display("FAIL first_read_valid got %b exp 1", bus.rd_valid); else passed++;
    total++; if (bus.rd_data_a !== '0 || bus.rd_data_b !== '0)
      $display("FAIL first_read_data got %h/%h exp 0/0", bus.rd_data_a, bus.rd_data_b); else passed++;
    tick();
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL valid_drop got %b exp 0", bus.rd_valid); else passed++;
  endtask

  task automatic test_write_read();
    bus.wr_en = 1'b1; bus.wr_sel = 32'h0000_0020; bus.wr_data = 32'hDEAD_BEEF;
    tick();
    bus.wr_en = 1'b0; bus.rd_req = 1'b1; bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd5;
    tick();
    bus.rd_req = 1'b0;
    total++; if (bus.rd_data_a !== 32'hDEAD_BEEF) $display("FAIL wr_rd_a got %h exp DEADBEEF", bus.rd_data_a); else passed++;
    total++; if (bus.rd_data_b !== 32'hDEAD_BEEF) $display("FAIL wr_rd_same_addr_b got %h exp DEADBEEF", bus.rd_data_b); else passed++;
    tick();
    total++; if (bus.rd_data_a !== 32'hDEAD_BEEF) $display("FAIL rd_hold got %h exp DEADBEEF", bus.rd_data_a); else passed++;
  endtask

  task automatic test_illegal();
    bus.wr_en = 1'b1; bus.wr_sel = 32'd123; bus.wr_data = 32'h1;
    tick();
    bus.wr_en = 1'b0;
    total++; if (bus.sel_err !== 1'b1) $display("FAIL illegal_sel_err got %b exp 1", bus.sel_err); else passed++;
    total++; if (bus.err_cnt !== 8'd1) $display("FAIL illegal_err_cnt got %0d exp 1", bus.err_cnt); else passed++;
    // registers 0,1,3,4,5,6 are named by 123; none may have changed
    for (int i = 0; i < 7; i++) begin
      bus.rd_req = 1'b1; bus.rd_addr_a = 5'(i); bus.rd_addr_b = 5'(31 - i);
      tick();
      total++; if (bus.rd_data_a !== mem[i]) $display("FAIL illegal_no_write r%0d got %h exp %h", i, bus.rd_data_a, mem[i]); else passed++;
    end
    bus.rd_req = 1'b0;
    for (int n = 0; n < 300; n++) begin
      bus.wr_en = 1'b1;
      bus.wr_sel = (n % 2 == 0) ? 32'd0 : (32'd3 << (n % 30));
      bus.wr_data = $urandom;
      tick();
    end
    bus.wr_en = 1'b0;
    total++; if (bus.err_cnt !== 8'hFF) $display("FAIL err_cnt_sat got %0d exp 255", bus.err_cnt); else passed++;
    total++; if (bus.sel_err !== 1'b1) $display("FAIL sel_err_sticky got %b exp 1", bus.sel_err); else passed++;
    total++; if (mem[5] !== 32'hDEAD_BEEF) $display("FAIL model_r5 got %h exp DEADBEEF", mem[5]); else passed++;
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] want;
    bus.wr_en = 1'b1; bus.wr_sel = 32'h0000_0080; bus.wr_data = 32'h1;
    tick();
    bus.wr_data = 32'hA5A5_A5A5;
    bus.rd_req = 1'b1; bus.rd_addr_a = 5'd7; bus.rd_addr_b = 5'd0;
    tick();
    bus.wr_en = 1'b0; bus.rd_req = 1'b0;
`ifdef REGFILE_BYPASS_EN
    want = 32'hA5A5_A5A5;
`else
    want = 32'h1;
`endif
    total++; if (bus.rd_data_a !== want) $display("FAIL same_cycle_rd_a got %h exp %h", bus.rd_data_a, want); else passed++;
    // illegal write touching register 7 must never be forwarded
    bus.wr_en = 1'b1; bus.wr_sel = 32'h0000_0180; bus.wr_data = 32'h5555_0000;
    bus.rd_req = 1'b1; bus.rd_addr_a = 5'd7;
    tick();
    bus.wr_en = 1'b0; bus.rd_req = 1'b0;
    total++; if (bus.rd_data_a !== 32'hA5A5_A5A5) $display("FAIL illegal_no_fwd got %h exp A5A5A5A5", bus.rd_data_a); else passed++;
  endtask

  task automatic test_reset_midread();
    bus.rd_req = 1'b1; bus.rd_addr_a = 5'd7; bus.rd_addr_b = 5'd5;
    #2 rst = 1'b0;
    #1;
    total++; if (bus.rd_valid !== 1'b0 || bus.rd_data_a !== '0 || bus.rd_data_b !== '0 || bus.err_cnt !== 8'd0 || bus.sel_err !== 1'b0)
      $display("FAIL async_reset got v=%b a=%h b=%h e=%b c=%0d exp all 0", bus.rd_valid, bus.rd_data_a, bus.rd_data_b, bus.sel_err, bus.err_cnt);
    else passed++;
    idle();
    model_clear();
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL stale_valid got %b exp 0", bus.rd_valid); else passed++;
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    total++; if (bus.rd_data_a !== '0 || bus.rd_data_b !== '0)
      $display("FAIL regs_cleared got %h/%h exp 0/0", bus.rd_data_a, bus.rd_data_b); else passed++;
  endtask

  task automatic test_back_to_back();
    int pulses;
    for (int i = 0; i < 32; i++) begin
      bus.wr_en = 1'b1; bus.wr_sel = 32'd1 << i; bus.wr_data = DW'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      bus.rd_req = 1'b1; bus.rd_addr_a = 5'(i); bus.rd_addr_b = 5'(31 - i);
      tick();
      if (bus.rd_valid === 1'b1) pulses++;
      total++; if (bus.rd_data_a !== DW'(i) || bus.rd_data_b !== DW'(31 - i))
        $display("FAIL b2b_data pair %0d got %h/%h exp %h/%h", i, bus.rd_data_a, bus.rd_data_b, DW'(i), DW'(31 - i));
      else passed++;
    end
    bus.rd_req = 1'b0;
    total++; if (pulses != 16) $display("FAIL b2b_pulses got %0d exp 16", pulses); else passed++;
    tick();
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL b2b_end_valid got %b exp 0", bus.rd_valid); else passed++;
  endtask

  task automatic test_random();
    int errs;
    apply_reset();
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      bus.wr_en   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0:       bus.wr_sel = $urandom;
        1:       bus.wr_sel = 32'd0;
        default: bus.wr_sel = 32'd1 << $urandom_range(0, 31);
      endcase
      bus.wr_data   = $urandom;
      bus.rd_req    = $urandom_range(0, 1);
      bus.rd_addr_a = 5'($urandom_range(0, 31));
      bus.rd_addr_b = ($urandom_range(0, 3) == 0) ? bus.rd_addr_a : 5'($urandom_range(0, 31));
      tick();
      if (bus.rd_valid !== exp_valid || bus.rd_data_a !== exp_a || bus.rd_data_b !== exp_b ||
          bus.sel_err !== exp_err || bus.err_cnt !== 8'(exp_cnt)) begin
        if (errs < 5)
          $display("FAIL random cyc %0d got v=%b a=%h b=%h e=%b c=%0d exp v=%b a=%h b=%h e=%b c=%0d",
                   n, bus.rd_valid, bus.rd_data_a, bus.rd_data_b, bus.sel_err, bus.err_cnt,
                   exp_valid, exp_a, exp_b, exp_err, exp_cnt);
        errs++;
      end
    end
    idle();
    total++; if (errs != 0) $display("FAIL random_total mismatching cycles %0d exp 0", errs); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_clear();
    #1;
    test_reset();
    test_write_read();
    test_illegal();
    test_same_cycle();
    test_reset_midread();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
